// File: rtl/gnn_result_streamer.sv
// gnn_result_streamer
// Output stage after the GNN datapath. It captures one frame of final-layer
// scores on the rising edge of the combined ready flags and streams them out
// one score per beat in node-major order. It also registers a per-node argmax
// class prediction and keeps sticky error flags for dropped frames and
// inconsistent ready flags.
module gnn_result_streamer #(
    parameter  int DW          = 21,
    parameter  int NUM_NODES   = 4,
    parameter  int NUM_CLASSES = 2,
    localparam int NE          = NUM_NODES * NUM_CLASSES,
    localparam int IW          = (NE > 1) ? $clog2(NE) : 1,
    localparam int NW          = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1,
    localparam int CW          = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NE*DW-1:0]            res_flat,
    input  logic [NE-1:0]               res_rdy,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic signed [DW-1:0]        m_data,
    output logic [NW-1:0]               m_node,
    output logic [CW-1:0]               m_class,
    output logic                        m_last,
    output logic [NUM_NODES*CW-1:0]     pred,
    output logic                        pred_valid,
    output logic                        busy,
    output logic                        overrun,
    output logic                        flag_err,
    input  logic                        clr_err
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_DRAIN = 1'b1;

    logic [0:0]              state;
    logic [IW-1:0]           idx;
    logic signed [DW-1:0]    score_buf [NE];
    logic                    rdy_prev;
    logic                    rdy_all;
    logic                    frame_evt;
    logic                    capture;
    logic                    xfer;
    logic                    at_last;
    logic                    partial;
    logic [NUM_NODES*CW-1:0] pred_next;

    // A frame is the rising edge of "every score ready"; a held level counts once.
    assign rdy_all   = &res_rdy;
    assign frame_evt = rdy_all & ~rdy_prev;
    assign capture   = frame_evt && (state == S_IDLE);
    assign xfer      = m_valid && m_ready;
    assign at_last   = (idx == IW'(NE - 1));
    assign partial   = (res_rdy != '0) && !rdy_all;
    assign m_valid   = (state == S_DRAIN);
    assign busy      = (state == S_DRAIN);

    // Remember the previous combined flag; starts high so flags already up at reset release are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_prev <= 1'b1;
        end else begin
            rdy_prev <= rdy_all;
        end
    end

    // Stream control: enter DRAIN on capture, advance per accepted beat, return to IDLE after the last one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            idx   <= '0;
        end else if (capture) begin
            state <= S_DRAIN;
            idx   <= '0;
        end else if ((state == S_DRAIN) && xfer) begin
            if (at_last) begin
                state <= S_IDLE;
                idx   <= '0;
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

    // Frame buffer: all scores latched together at capture, untouched while draining.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int e = 0; e < NE; e++) begin
                score_buf[e] <= '0;
            end
        end else if (capture) begin
            for (int e = 0; e < NE; e++) begin
                score_buf[e] <= res_flat[e*DW +: DW];
            end
        end
    end

    // Per-node argmax of the incoming scores; strict greater-than keeps the lowest class on ties.
    always_comb begin
        logic signed [DW-1:0] best_val;
        logic signed [DW-1:0] cand;
        logic [CW-1:0]        best_cls;
        pred_next = '0;
        best_val  = '0;
        cand      = '0;
        best_cls  = '0;
        for (int n = 0; n < NUM_NODES; n++) begin
            best_val = res_flat[(n*NUM_CLASSES)*DW +: DW];
            best_cls = '0;
            for (int c = 1; c < NUM_CLASSES; c++) begin
                cand = res_flat[(n*NUM_CLASSES + c)*DW +: DW];
                if (cand > best_val) begin
                    best_val = cand;
                    best_cls = CW'(c);
                end
            end
            pred_next[n*CW +: CW] = best_cls;
        end
    end

    // Prediction register with a one-cycle update pulse on every captured frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred       <= '0;
            pred_valid <= 1'b0;
        end else begin
            pred_valid <= capture;
            if (capture) begin
                pred <= pred_next;
            end
        end
    end

    // Sticky error flags; a new error in the same cycle as a clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun  <= 1'b0;
            flag_err <= 1'b0;
        end else begin
            if (frame_evt && (state == S_DRAIN)) begin
                overrun <= 1'b1;
            end else if (clr_err) begin
                overrun <= 1'b0;
            end
            if (partial) begin
                flag_err <= 1'b1;
            end else if (clr_err) begin
                flag_err <= 1'b0;
            end
        end
    end

    // Beat presentation from the buffer; outputs read as zero whenever no beat is offered.
    always_comb begin
        int unsigned idx_u;
        idx_u   = 32'(idx);
        m_data  = '0;
        m_node  = '0;
        m_class = '0;
        m_last  = 1'b0;
        if (m_valid) begin
            m_data  = score_buf[idx];
            m_node  = NW'(idx_u / NUM_CLASSES);
            m_class = CW'(idx_u % NUM_CLASSES);
            m_last  = at_last;
        end
    end

endmodule

// File: tb/tb_gnn_result_streamer.sv
// tb_gnn_result_streamer
// Directed and randomized bench for gnn_result_streamer. A frame-level model
// (queue of expected beats, argmax by max-then-first-match, sticky flags)
// predicts every output each cycle; outputs are compared on the falling edge.
module tb_gnn_result_streamer;

    localparam int DW = 21;
    localparam int NN = 4;
    localparam int NC = 2;
    localparam int NE = NN * NC;
    localparam int NW = 2;
    localparam int CW = 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NE*DW-1:0]  res_flat;
    logic [NE-1:0]     res_rdy;
    logic              m_valid;
    logic              m_ready;
    logic [DW-1:0]     m_data;
    logic [NW-1:0]     m_node;
    logic [CW-1:0]     m_class;
    logic              m_last;
    logic [NN*CW-1:0]  pred;
    logic              pred_valid;
    logic              busy;
    logic              overrun;
    logic              flag_err;
    logic              clr_err;

    typedef struct {
        logic [DW-1:0] data;
        int            node;
        int            cls;
        logic          last;
    } beat_t;

    beat_t            exp_q[$];
    logic [DW-1:0]    scores [NE];
    logic             exp_prev_all;
    logic [NN*CW-1:0] exp_pred;
    logic             exp_pv;
    logic             exp_ovr;
    logic             exp_ferr;
    int               n_pass  = 0;
    int               n_fail  = 0;
    int               n_check = 0;

    int t1_vals [NE] = '{5, -3, -7, 2, 0, 0, -1048576, 1048575};

    gnn_result_streamer #(.DW(DW), .NUM_NODES(NN), .NUM_CLASSES(NC)) dut (
        .clk(clk), .rst_n(rst_n), .res_flat(res_flat), .res_rdy(res_rdy),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_node(m_node),
        .m_class(m_class), .m_last(m_last), .pred(pred), .pred_valid(pred_valid),
        .busy(busy), .overrun(overrun), .flag_err(flag_err), .clr_err(clr_err)
    );

    // Free-running clock
    always #5 clk = ~clk;

    function automatic logic [NE*DW-1:0] pack_scores();
        logic [NE*DW-1:0] v;
        v = '0;
        for (int i = 0; i < NE; i++) v[i*DW +: DW] = scores[i];
        return v;
    endfunction

    // Argmax as "find the maximum, then pick the first class holding it"
    function automatic logic [NN*CW-1:0] model_argmax();
        logic [NN*CW-1:0] p;
        int               maxv;
        int               best;
        p = '0;
        for (int n = 0; n < NN; n++) begin
            maxv = $signed(scores[n*NC]);
            for (int c = 0; c < NC; c++)
                if ($signed(scores[n*NC + c]) > maxv) maxv = $signed(scores[n*NC + c]);
            best = NC;
            for (int c = NC - 1; c >= 0; c--)
                if ($signed(scores[n*NC + c]) == maxv) best = c;
            p[n*CW +: CW] = CW'(best);
        end
        return p;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        exp_prev_all = 1'b1;
        exp_pred     = '0;
        exp_pv       = 1'b0;
        exp_ovr      = 1'b0;
        exp_ferr     = 1'b0;
    endtask

    // What the next clock edge does to the frame-level state
    task automatic model_edge();
        logic  all_set;
        logic  evt;
        logic  was_busy;
        logic  set_ferr;
        beat_t b;
        all_set      = &res_rdy;
        evt          = all_set && !exp_prev_all;
        exp_prev_all = all_set;
        was_busy     = (exp_q.size() > 0);
        if (was_busy && m_ready) void'(exp_q.pop_front());
        exp_pv = 1'b0;
        if (evt && !was_busy) begin
            for (int n = 0; n < NN; n++)
                for (int c = 0; c < NC; c++) begin
                    b.data = scores[n*NC + c];
                    b.node = n;
                    b.cls  = c;
                    b.last = (n == NN - 1) && (c == NC - 1);
                    exp_q.push_back(b);
                end
            exp_pred = model_argmax();
            exp_pv   = 1'b1;
        end
        set_ferr = (res_rdy != '0) && !all_set;
        exp_ovr  = (evt && was_busy) || (exp_ovr && !clr_err);
        exp_ferr = set_ferr || (exp_ferr && !clr_err);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_check++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    task automatic checkOutput();
        logic v;
        v = (exp_q.size() > 0);
        check("m_valid", 64'(m_valid), 64'(v));
        check("busy", 64'(busy), 64'(v));
        if (v) begin
            check("m_data", 64'(m_data), 64'(exp_q[0].data));
            check("m_node", 64'(m_node), 64'(exp_q[0].node));
            check("m_class", 64'(m_class), 64'(exp_q[0].cls));
            check("m_last", 64'(m_last), 64'(exp_q[0].last));
        end else begin
            check("idle_m_data", 64'(m_data), 64'(0));
            check("idle_m_last", 64'(m_last), 64'(0));
        end
        check("pred", 64'(pred), 64'(exp_pred));
        check("pred_valid", 64'(pred_valid), 64'(exp_pv));
        check("overrun", 64'(overrun), 64'(exp_ovr));
        check("flag_err", 64'(flag_err), 64'(exp_ferr));
    endtask

    // One clock cycle: drive inputs, advance the model, check after the edge
    task automatic applyStimulus(input logic [NE-1:0] rdy, input logic rd, input logic clr);
        res_rdy  = rdy;
        m_ready  = rd;
        clr_err  = clr;
        res_flat = pack_scores();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        checkOutput();
    endtask

    task automatic load_t1();
        for (int i = 0; i < NE; i++) scores[i] = DW'(t1_vals[i]);
    endtask

    task automatic load_random();
        for (int i = 0; i < NE; i++) begin
            case ($urandom_range(0, 5))
                0:       scores[i] = {1'b1, {(DW-1){1'b0}}};
                1:       scores[i] = {1'b0, {(DW-1){1'b1}}};
                2:       scores[i] = '0;
                default: scores[i] = DW'($urandom);
            endcase
        end
    endtask

    // Drain the current frame with a stall pattern: 0 = always ready, 1 = 1,0,0 repeating
    task automatic drain(input logic [NE-1:0] rdy, input int mode);
        for (int k = 0; k < 64 && exp_q.size() > 0; k++)
            applyStimulus(rdy, (mode == 0) ? 1'b1 : ((k % 3) == 0), 1'b0);
    endtask

    initial begin
        rst_n    = 1'b0;
        res_rdy  = '0;
        m_ready  = 1'b0;
        clr_err  = 1'b0;
        for (int i = 0; i < NE; i++) scores[i] = '0;
        res_flat = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        $display("[TB] reset state");
        checkOutput();
        rst_n = 1'b1;

        $display("[TB] T1 basic frame");
        load_t1();
        applyStimulus('0, 1'b1, 1'b0);
        applyStimulus('1, 1'b1, 1'b0);
        drain('1, 0);
        applyStimulus('1, 1'b1, 1'b0);
        check("t1_pred", 64'(pred), 64'(4'b1010));

        $display("[TB] T2 stalled drain");
        applyStimulus('0, 1'b1, 1'b0);
        applyStimulus('1, 1'b0, 1'b0);
        drain('1, 1);

        $display("[TB] T3 held flags");
        applyStimulus('0, 1'b1, 1'b0);
        applyStimulus('1, 1'b1, 1'b0);
        drain('1, 0);
        for (int k = 0; k < 20; k++) applyStimulus('1, 1'b1, 1'b0);
        check("t3_no_overrun", 64'(overrun), 64'(0));
        check("t3_idle", 64'(busy), 64'(0));

        $display("[TB] T4 overrun during stall");
        applyStimulus('0, 1'b1, 1'b0);
        load_random();
        applyStimulus('1, 1'b1, 1'b0);
        applyStimulus('1, 1'b1, 1'b0);
        applyStimulus('1, 1'b1, 1'b0);
        applyStimulus('0, 1'b0, 1'b0);
        load_random();
        applyStimulus('1, 1'b0, 1'b0);
        check("t4_overrun", 64'(overrun), 64'(1));
        applyStimulus('1, 1'b0, 1'b0);
        drain('1, 0);
        applyStimulus('1, 1'b1, 1'b1);
        check("t4_cleared", 64'(overrun), 64'(0));

        $display("[TB] T5 partial flags");
        applyStimulus('0, 1'b1, 1'b0);
        applyStimulus(8'h0F, 1'b1, 1'b0);
        check("t5_flag_err", 64'(flag_err), 64'(1));
        applyStimulus('0, 1'b1, 1'b0);
        check("t5_no_capture", 64'(busy), 64'(0));
        applyStimulus('0, 1'b1, 1'b1);

        $display("[TB] T6 reset mid-drain");
        load_t1();
        applyStimulus('1, 1'b1, 1'b0);
        applyStimulus('1, 1'b1, 1'b0);
        applyStimulus('1, 1'b1, 1'b0);
        #1 rst_n = 1'b0;
        #1 model_reset();
        checkOutput();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) applyStimulus('1, 1'b1, 1'b0);
        applyStimulus('0, 1'b1, 1'b0);
        applyStimulus('1, 1'b1, 1'b0);
        drain('1, 0);

        $display("[TB] randomized frames");
        for (int it = 0; it < 40; it++) begin
            load_random();
            applyStimulus(($urandom_range(0, 7) == 0) ? NE'($urandom) : '0, 1'b1, 1'b0);
            applyStimulus('1, $urandom_range(0, 1) == 1, 1'b0);
            for (int k = 0; k < 16; k++) begin
                if ($urandom_range(0, 3) == 0) load_random();
                applyStimulus(($urandom_range(0, 5) == 0) ? '0 : '1,
                              $urandom_range(0, 3) != 0,
                              $urandom_range(0, 7) == 0);
            end
            drain('1, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_check);
        $finish;
    end

endmodule
